// File: rtl/receive_capture_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_if
// Brief    : Valid/ready stream bundle; "realtime" modports carry no ready.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;

    modport master_full     (output valid, output data, output last, input ready);
    modport slave_full      (input valid, input data, input last, output ready);
    modport master_realtime (output valid, output data);
    modport slave_realtime  (input valid, input data);
endinterface
`default_nettype wire

// File: rtl/receive_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : receive_capture_sequencer
// Brief    : Arm/trigger/capture/readout/holdoff sequencer driving the sample
//            buffer's start/stop config words. Option: RECEIVE_SEQ_AUTO_REARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module receive_capture_sequencer #(
    parameter int CHANNELS      = 8,
    parameter int CAPTURE_WIDTH = 32,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    axis_if.slave_realtime       seq_config,
    input  logic                 start_cmd,
    input  logic                 abort_cmd,
    input  logic                 trigger_in,
    input  logic                 dma_last_xfer,
    axis_if.master_full          buffer_config,
    output logic [2:0]           state,
    output logic                 busy,
    output logic [31:0]          capture_count
);
    localparam int BANK_W = $clog2($clog2(CHANNELS) + 1);
    localparam int CFG_W  = HOLDOFF_WIDTH + CAPTURE_WIDTH + BANK_W;
    localparam int CNT_W  = (CAPTURE_WIDTH > HOLDOFF_WIDTH) ? CAPTURE_WIDTH : HOLDOFF_WIDTH;
    localparam int WORD_W = BANK_W + 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_START_WR = 3'd2,
        S_CAPTURE  = 3'd3,
        S_STOP_WR  = 3'd4,
        S_READOUT  = 3'd5,
        S_HOLDOFF  = 3'd6
    } state_t;

    state_t                     r_state, w_state_nxt;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic                       r_abort_pend, w_abort_pend_nxt;
    logic                       r_valid, w_valid_nxt;
    logic [WORD_W-1:0]          r_data, w_data_nxt;
    logic [31:0]                r_capture_count, w_capture_count_nxt;
    logic                       r_busy;
    logic [HOLDOFF_WIDTH-1:0]   r_holdoff;
    logic [CAPTURE_WIDTH-1:0]   r_capture_cycles;
    logic [BANK_W-1:0]          r_bank;

    logic                       w_hs;
    logic [WORD_W-1:0]          w_start_word;
    logic [WORD_W-1:0]          w_stop_word;

    assign w_hs         = r_valid & buffer_config.ready;
    assign w_start_word = {r_bank, 2'b10};
    assign w_stop_word  = {r_bank, 2'b01};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_abort_pend     <= 1'b0;
            r_valid          <= 1'b0;
            r_data           <= '0;
            r_capture_count  <= '0;
            r_busy           <= 1'b0;
            r_holdoff        <= '0;
            r_capture_cycles <= '0;
            r_bank           <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_abort_pend     <= w_abort_pend_nxt;
            r_valid          <= w_valid_nxt;
            r_data           <= w_data_nxt;
            r_capture_count  <= w_capture_count_nxt;
            r_busy           <= (w_state_nxt != S_IDLE);
            // Config is only taken while idle so a run never sees a half-updated window.
            if (r_state == S_IDLE && seq_config.valid) begin
                r_holdoff        <= seq_config.data[CFG_W-1 -: HOLDOFF_WIDTH];
                r_capture_cycles <= seq_config.data[CAPTURE_WIDTH+BANK_W-1 -: CAPTURE_WIDTH];
                r_bank           <= seq_config.data[BANK_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_abort_pend_nxt    = r_abort_pend;
        w_valid_nxt         = r_valid;
        w_data_nxt          = r_data;
        w_capture_count_nxt = r_capture_count;

        case (r_state)
            S_IDLE: begin
                if (start_cmd && !abort_cmd) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (abort_cmd) begin
                    w_state_nxt = S_IDLE;
                end else if (trigger_in) begin
                    w_state_nxt = S_START_WR;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_start_word;
                end
            end
            S_START_WR: begin
                if (abort_cmd) w_abort_pend_nxt = 1'b1;
                if (w_hs) begin
                    w_valid_nxt = 1'b0;
                    // An aborted start still needs a stop word; it goes out after a bubble.
                    if (abort_cmd || r_abort_pend) begin
                        w_state_nxt = S_STOP_WR;
                    end else begin
                        w_state_nxt = S_CAPTURE;
                        w_cnt_nxt   = CNT_W'(r_capture_cycles);
                    end
                end
            end
            S_CAPTURE: begin
                if (abort_cmd || r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_STOP_WR;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_stop_word;
                    if (abort_cmd) w_abort_pend_nxt = 1'b1;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_STOP_WR: begin
                if (abort_cmd) w_abort_pend_nxt = 1'b1;
                if (w_hs) begin
                    w_state_nxt = S_READOUT;
                    w_valid_nxt = 1'b0;
                end else if (!r_valid) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_stop_word;
                end
            end
            S_READOUT: begin
                if (abort_cmd) w_abort_pend_nxt = 1'b1;
                if (dma_last_xfer) begin
                    w_state_nxt         = S_HOLDOFF;
                    w_cnt_nxt           = CNT_W'(r_holdoff);
                    w_capture_count_nxt = r_capture_count + 32'd1;
                end
            end
            S_HOLDOFF: begin
                if (abort_cmd) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
`ifdef RECEIVE_SEQ_AUTO_REARM_EN
                    w_state_nxt = r_abort_pend ? S_IDLE : S_ARMED;
`else
                    w_state_nxt = S_IDLE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase

        if (w_state_nxt == S_IDLE) w_abort_pend_nxt = 1'b0;
    end

    assign state              = r_state;
    assign busy               = r_busy;
    assign capture_count      = r_capture_count;
    assign buffer_config.valid = r_valid;
    assign buffer_config.data  = r_data;
    assign buffer_config.last  = 1'b0;
endmodule
`default_nettype wire

// File: tb/tb_receive_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_receive_capture_sequencer
// Brief    : Scoreboarded bench for receive_capture_sequencer config words,
//            phase timing, abort paths and optional auto-rearm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_receive_capture_sequencer;
    localparam int CFG_W = 16 + 32 + 2;
    localparam logic [2:0] C_IDLE = 3'd0, C_ARMED = 3'd1, C_START_WR = 3'd2,
                           C_CAPTURE = 3'd3, C_STOP_WR = 3'd4, C_READOUT = 3'd5,
                           C_HOLDOFF = 3'd6;

    logic        clk = 1'b0;
    logic        reset, start_cmd, abort_cmd, trigger_in, dma_last_xfer;
    logic [2:0]  state;
    logic        busy;
    logic [31:0] capture_count;

    axis_if #(.DATA_W(CFG_W)) seq_if ();
    axis_if #(.DATA_W(4))     bc_if ();

    always #5 clk = ~clk;

    receive_capture_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .seq_config    (seq_if),
        .start_cmd     (start_cmd),
        .abort_cmd     (abort_cmd),
        .trigger_in    (trigger_in),
        .dma_last_xfer (dma_last_xfer),
        .buffer_config (bc_if),
        .state         (state),
        .busy          (busy),
        .capture_count (capture_count)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_words  = 0;
    logic [3:0] exp_q[$];
    logic       stall_prev = 1'b0;
    logic [3:0] data_prev  = 4'd0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Config-word scoreboard and hold-while-stalled monitor.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("hold_valid", 64'(bc_if.valid), 64'd1);
                check_eq("hold_data", 64'(bc_if.data), 64'(data_prev));
            end
            if (bc_if.valid && bc_if.ready) begin
                n_words++;
                if (exp_q.size() == 0) check_eq("unexpected_word", 64'(bc_if.data), 64'hDEAD);
                else check_eq("cfg_word", 64'(bc_if.data), 64'(exp_q.pop_front()));
            end
            stall_prev = bc_if.valid && !bc_if.ready;
            data_prev  = bc_if.data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_start(input logic [15:0] h, input logic [31:0] c, input logic [1:0] b);
        seq_if.valid = 1'b1;
        seq_if.data  = {h, c, b};
        start_cmd    = 1'b1;
        tick();
        seq_if.valid = 1'b0;
        start_cmd    = 1'b0;
    endtask

    task automatic fire_trigger(input logic [1:0] b, input bit with_stop);
        exp_q.push_back({b, 2'b10});
        if (with_stop) exp_q.push_back({b, 2'b01});
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int k = 0;
        while (state !== s && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 64'(state), 64'(s));
    endtask

    task automatic run_len(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (state === s && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_abort();
        abort_cmd = 1'b1;
        tick();
        abort_cmd = 1'b0;
    endtask

    // Drain readout, check holdoff length, leave the block idle.
    task automatic finish_run(input int hold_cycles, input string tag);
        int n;
        wait_state(C_READOUT, 20, {tag, "_readout"});
        dma_last_xfer = 1'b1;
        tick();
        dma_last_xfer = 1'b0;
        check_eq({tag, "_holdoff"}, 64'(state), 64'(C_HOLDOFF));
        run_len(C_HOLDOFF, 100, n);
        check_eq({tag, "_holdoff_len"}, 64'(n), 64'(hold_cycles));
`ifdef RECEIVE_SEQ_AUTO_REARM_EN
        check_eq({tag, "_rearmed"}, 64'(state), 64'(C_ARMED));
        if (state === C_ARMED) pulse_abort();
`endif
        check_eq({tag, "_idle"}, 64'(state), 64'(C_IDLE));
        check_eq({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int w;
        reset = 1'b1; start_cmd = 1'b0; abort_cmd = 1'b0; trigger_in = 1'b0;
        dma_last_xfer = 1'b0;
        seq_if.valid = 1'b0; seq_if.data = '0; seq_if.ready = 1'b0; seq_if.last = 1'b0;
        bc_if.ready = 1'b1;
        tick(); tick();
        check_eq("rst_state", 64'(state), 64'(C_IDLE));
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_valid", 64'(bc_if.valid), 64'd0);
        check_eq("rst_data", 64'(bc_if.data), 64'd0);
        check_eq("rst_count", 64'(capture_count), 64'd0);
        reset = 1'b0;
        tick();

        // Nominal run: holdoff 2, capture 5, bank 1, config and start together.
        cfg_start(16'd2, 32'd5, 2'd1);
        check_eq("t1_armed", 64'(state), 64'(C_ARMED));
        check_eq("t1_busy", 64'(busy), 64'd1);
        fire_trigger(2'd1, 1'b1);
        check_eq("t1_start_state", 64'(state), 64'(C_START_WR));
        check_eq("t1_start_valid", 64'(bc_if.valid), 64'd1);
        check_eq("t1_start_data", 64'(bc_if.data), 64'h6);
        tick();
        check_eq("t1_capture", 64'(state), 64'(C_CAPTURE));
        check_eq("t1_valid_drop", 64'(bc_if.valid), 64'd0);
        run_len(C_CAPTURE, 50, n);
        check_eq("t1_capture_len", 64'(n), 64'd5);
        check_eq("t1_stop_state", 64'(state), 64'(C_STOP_WR));
        check_eq("t1_stop_data", 64'(bc_if.data), 64'h5);
        tick();
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        check_eq("t1_trig_ignored", 64'(state), 64'(C_READOUT));
        finish_run(3, "t1");
        check_eq("t1_count", 64'(capture_count), 64'd1);

        // Stalled start word: ready low for 4 cycles.
        bc_if.ready = 1'b0;
        cfg_start(16'd0, 32'd3, 2'd2);
        fire_trigger(2'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_stall_state", 64'(state), 64'(C_START_WR));
            tick();
        end
        bc_if.ready = 1'b1;
        check_eq("t2_still_start", 64'(state), 64'(C_START_WR));
        tick();
        check_eq("t2_capture", 64'(state), 64'(C_CAPTURE));
        run_len(C_CAPTURE, 50, n);
        check_eq("t2_capture_len", 64'(n), 64'd3);
        finish_run(1, "t2");

        // Unbounded capture ended by abort.
        cfg_start(16'd1, 32'd0, 2'd0);
        fire_trigger(2'd0, 1'b1);
        wait_state(C_CAPTURE, 5, "t3_capture");
        repeat (100) tick();
        check_eq("t3_unbounded", 64'(state), 64'(C_CAPTURE));
        pulse_abort();
        check_eq("t3_stop", 64'(state), 64'(C_STOP_WR));
        wait_state(C_READOUT, 5, "t3_readout");
        dma_last_xfer = 1'b1;
        tick();
        dma_last_xfer = 1'b0;
        run_len(C_HOLDOFF, 50, n);
        check_eq("t3_holdoff_len", 64'(n), 64'd2);
        check_eq("t3_idle", 64'(state), 64'(C_IDLE));
        check_eq("t3_q_empty", 64'(exp_q.size()), 64'd0);
        check_eq("t3_count", 64'(capture_count), 64'd3);

        // Abort in ARMED, start+abort in IDLE, stray trigger/dma in IDLE.
        w = n_words;
        start_cmd = 1'b1;
        tick();
        start_cmd = 1'b0;
        check_eq("t4_armed", 64'(state), 64'(C_ARMED));
        pulse_abort();
        check_eq("t4_abort_idle", 64'(state), 64'(C_IDLE));
        start_cmd = 1'b1; abort_cmd = 1'b1;
        tick();
        start_cmd = 1'b0; abort_cmd = 1'b0;
        check_eq("t4_start_abort", 64'(state), 64'(C_IDLE));
        trigger_in = 1'b1; dma_last_xfer = 1'b1;
        tick();
        trigger_in = 1'b0; dma_last_xfer = 1'b0;
        tick();
        check_eq("t4_stray_state", 64'(state), 64'(C_IDLE));
        check_eq("t4_stray_count", 64'(capture_count), 64'd3);
        check_eq("t4_no_words", 64'(n_words), 64'(w));

        // Config presented mid-capture is ignored.
        cfg_start(16'd0, 32'd4, 2'd2);
        fire_trigger(2'd2, 1'b1);
        wait_state(C_CAPTURE, 5, "t5_capture");
        seq_if.valid = 1'b1;
        seq_if.data  = {16'd0, 32'd7, 2'd3};
        tick();
        seq_if.valid = 1'b0;
        run_len(C_CAPTURE, 50, n);
        check_eq("t5_old_len", 64'(n + 1), 64'd4);
        finish_run(1, "t5a");
        cfg_start(16'd0, 32'd7, 2'd3);
        fire_trigger(2'd3, 1'b1);
        wait_state(C_CAPTURE, 5, "t5_capture2");
        run_len(C_CAPTURE, 50, n);
        check_eq("t5_new_len", 64'(n), 64'd7);
        finish_run(1, "t5b");

        // Reset mid-capture: idle next cycle, no stop word.
        cfg_start(16'd0, 32'd0, 2'd1);
        fire_trigger(2'd1, 1'b0);
        wait_state(C_CAPTURE, 5, "t6_capture");
        reset = 1'b1;
        tick();
        check_eq("t6_rst_state", 64'(state), 64'(C_IDLE));
        check_eq("t6_rst_valid", 64'(bc_if.valid), 64'd0);
        check_eq("t6_rst_count", 64'(capture_count), 64'd0);
        reset = 1'b0;
        repeat (3) tick();
        check_eq("t6_idle", 64'(state), 64'(C_IDLE));
        check_eq("t6_q_empty", 64'(exp_q.size()), 64'd0);

`ifdef RECEIVE_SEQ_AUTO_REARM_EN
        // Continuous acquisition, then abort during readout.
        cfg_start(16'd1, 32'd2, 2'd1);
        for (int i = 0; i < 3; i++) begin
            fire_trigger(2'd1, 1'b1);
            wait_state(C_READOUT, 20, "t7_readout");
            dma_last_xfer = 1'b1;
            tick();
            dma_last_xfer = 1'b0;
            wait_state(C_ARMED, 10, "t7_rearm");
        end
        check_eq("t7_count", 64'(capture_count), 64'd3);
        fire_trigger(2'd1, 1'b1);
        wait_state(C_READOUT, 20, "t7_readout_abort");
        pulse_abort();
        check_eq("t7_drain", 64'(state), 64'(C_READOUT));
        dma_last_xfer = 1'b1;
        tick();
        dma_last_xfer = 1'b0;
        run_len(C_HOLDOFF, 50, n);
        check_eq("t7_holdoff_len", 64'(n), 64'd2);
        check_eq("t7_idle", 64'(state), 64'(C_IDLE));
        check_eq("t7_count_final", 64'(capture_count), 64'd4);
        check_eq("t7_q_empty", 64'(exp_q.size()), 64'd0);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
